// File: rtl/rop_depth_pkg.sv
// Shared definitions for the ROP depth-bounds front end: result codes and
// the per-tile sequencer state encoding.
package rop_depth_pkg;

  localparam int WIDTH_DEF = 24;

  localparam logic [1:0] DB_REJECT  = 2'b00;
  localparam logic [1:0] DB_ACCEPT  = 2'b01;
  localparam logic [1:0] DB_INCONCL = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    META,
    WAIT,
    CLASS,
    RESULT,
    FRAG
  } db_state_e;

endpackage

// File: rtl/depth_bounds_unit.sv
// Combinational depth-bounds compare: classifies a tile's Z range and tests a
// single fragment Z against the active bounds (all compares unsigned).
module depth_bounds_unit
  import rop_depth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] bound_min,
  input  logic [WIDTH-1:0] bound_max,
  input  logic [WIDTH-1:0] tile_z_min,
  input  logic [WIDTH-1:0] tile_z_max,
  input  logic             tile_err,
  input  logic [WIDTH-1:0] frag_z,
  output logic [1:0]       tile_code,
  output logic             frag_pass
);

  // An empty bounds window rejects everything, even tiles with bad metadata.
  always_comb begin
    tile_code = DB_INCONCL;
    if (bound_min > bound_max) begin
      tile_code = DB_REJECT;
    end else if (tile_err) begin
      tile_code = DB_INCONCL;
    end else if ((tile_z_max < bound_min) || (tile_z_min > bound_max)) begin
      tile_code = DB_REJECT;
    end else if ((tile_z_min >= bound_min) && (tile_z_max <= bound_max)) begin
      tile_code = DB_ACCEPT;
    end
  end

  assign frag_pass = (frag_z >= bound_min) && (frag_z <= bound_max);

endmodule

// File: rtl/depth_bounds_ctrl.sv
// Per-tile depth-bounds sequencer: HiZ metadata fetch, tile classification,
// per-fragment bounds test for inconclusive tiles, and tile statistics.
module depth_bounds_ctrl
  import rop_depth_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int TILE_ID_W = 16,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic                 cfg_bounds_en,
  input  logic [WIDTH-1:0]     cfg_bound_min,
  input  logic [WIDTH-1:0]     cfg_bound_max,
  input  logic                 tile_valid,
  output logic                 tile_ready,
  input  logic [TILE_ID_W-1:0] tile_id,
  output logic                 meta_req_valid,
  input  logic                 meta_req_ready,
  output logic [TILE_ID_W-1:0] meta_req_id,
  input  logic                 meta_rsp_valid,
  input  logic                 meta_rsp_err,
  input  logic [WIDTH-1:0]     meta_z_min,
  input  logic [WIDTH-1:0]     meta_z_max,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [TILE_ID_W-1:0] res_id,
  output logic [1:0]           res_code,
  input  logic                 frag_in_valid,
  output logic                 frag_in_ready,
  input  logic [WIDTH-1:0]     frag_in_z,
  input  logic                 frag_in_last,
  output logic                 frag_out_valid,
  input  logic                 frag_out_ready,
  output logic                 frag_out_pass,
  output logic                 frag_out_last,
  output logic [CNT_W-1:0]     stat_reject,
  output logic [CNT_W-1:0]     stat_accept,
  output logic [CNT_W-1:0]     stat_inconcl
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  db_state_e state_q, state_d;
  logic                 pend_en_q, pend_en_d;
  logic [WIDTH-1:0]     pend_min_q, pend_min_d, pend_max_q, pend_max_d;
  logic [WIDTH-1:0]     act_min_q, act_min_d, act_max_q, act_max_d;
  logic [TILE_ID_W-1:0] tid_q, tid_d;
  logic [WIDTH-1:0]     zmin_q, zmin_d, zmax_q, zmax_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic                 fov_q, fov_d, fpass_q, fpass_d, flast_q, flast_d;
  logic                 last_in_q, last_in_d;
  logic [CNT_W-1:0]     rej_q, rej_d, acc_q, acc_d, inc_q, inc_d;
  logic [1:0]           unit_code;
  logic                 unit_pass;
  logic                 frag_acc, frag_out_hs;

  depth_bounds_unit #(.WIDTH(WIDTH)) u_unit (
    .bound_min  (act_min_q),
    .bound_max  (act_max_q),
    .tile_z_min (zmin_q),
    .tile_z_max (zmax_q),
    .tile_err   (err_q),
    .frag_z     (frag_in_z),
    .tile_code  (unit_code),
    .frag_pass  (unit_pass)
  );

  assign tile_ready     = (state_q == IDLE);
  assign meta_req_valid = (state_q == META);
  assign res_valid      = (state_q == RESULT);
  // Once the tile's last fragment is in, hold off the next tile's fragments.
  assign frag_in_ready  = (state_q == FRAG) && !last_in_q && (!fov_q || frag_out_ready);
  assign frag_acc       = frag_in_valid && frag_in_ready;
  assign frag_out_hs    = fov_q && frag_out_ready;

  assign meta_req_id    = tid_q;
  assign res_id         = tid_q;
  assign res_code       = code_q;
  assign frag_out_valid = fov_q;
  assign frag_out_pass  = fpass_q;
  assign frag_out_last  = flast_q;
  assign stat_reject    = rej_q;
  assign stat_accept    = acc_q;
  assign stat_inconcl   = inc_q;

  always_comb begin
    state_d    = state_q;
    pend_en_d  = pend_en_q;
    pend_min_d = pend_min_q;
    pend_max_d = pend_max_q;
    act_min_d  = act_min_q;
    act_max_d  = act_max_q;
    tid_d      = tid_q;
    zmin_d     = zmin_q;
    zmax_d     = zmax_q;
    err_d      = err_q;
    code_d     = code_q;
    fov_d      = fov_q;
    fpass_d    = fpass_q;
    flast_d    = flast_q;
    last_in_d  = last_in_q;
    rej_d      = rej_q;
    acc_d      = acc_q;
    inc_d      = inc_q;

    if (cfg_we) begin
      pend_en_d  = cfg_bounds_en;
      pend_min_d = cfg_bound_min;
      pend_max_d = cfg_bound_max;
    end

    unique case (state_q)
      IDLE: begin
        // Snapshot uses the pre-write pending copy; a same-cycle cfg_we waits.
        if (tile_valid) begin
          tid_d     = tile_id;
          act_min_d = pend_min_q;
          act_max_d = pend_max_q;
          if (!pend_en_q) begin
            code_d  = DB_ACCEPT;
            state_d = RESULT;
          end else begin
            state_d = META;
          end
        end
      end
      META: begin
        if (meta_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (meta_rsp_valid) begin
          zmin_d  = meta_z_min;
          zmax_d  = meta_z_max;
          err_d   = meta_rsp_err;
          state_d = CLASS;
        end
      end
      CLASS: begin
        code_d  = unit_code;
        state_d = RESULT;
      end
      RESULT: begin
        if (res_ready) begin
          unique case (code_q)
            DB_REJECT: rej_d = sat_inc(rej_q);
            DB_ACCEPT: acc_d = sat_inc(acc_q);
            default:   inc_d = sat_inc(inc_q);
          endcase
          last_in_d = 1'b0;
          state_d   = (code_q == DB_INCONCL) ? FRAG : IDLE;
        end
      end
      FRAG: begin
        if (frag_out_hs) fov_d = 1'b0;
        if (frag_acc) begin
          fov_d   = 1'b1;
          fpass_d = unit_pass;
          flast_d = frag_in_last;
          if (frag_in_last) last_in_d = 1'b1;
        end
        if (frag_out_hs && flast_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_en_q  <= 1'b0;
      pend_min_q <= '0;
      pend_max_q <= '1;
      act_min_q  <= '0;
      act_max_q  <= '1;
      tid_q      <= '0;
      code_q     <= DB_REJECT;
      fov_q      <= 1'b0;
      fpass_q    <= 1'b0;
      flast_q    <= 1'b0;
      last_in_q  <= 1'b0;
      rej_q      <= '0;
      acc_q      <= '0;
      inc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_en_q  <= pend_en_d;
      pend_min_q <= pend_min_d;
      pend_max_q <= pend_max_d;
      act_min_q  <= act_min_d;
      act_max_q  <= act_max_d;
      tid_q      <= tid_d;
      code_q     <= code_d;
      fov_q      <= fov_d;
      fpass_q    <= fpass_d;
      flast_q    <= flast_d;
      last_in_q  <= last_in_d;
      rej_q      <= rej_d;
      acc_q      <= acc_d;
      inc_q      <= inc_d;
    end
  end

  // Metadata capture is pure data; only the FSM decides when it is meaningful.
  always_ff @(posedge clk) begin
    zmin_q <= zmin_d;
    zmax_q <= zmax_d;
    err_q  <= err_d;
  end

endmodule
